bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_digit_adj.sv | 18 +
 rtl/bcd_to_bin_seq.sv | 137 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, converter state encoding and digit helpers.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A BCD digit is legal only in the range 0..9.
    function automatic logic is_valid_digit(input logic [BCD_DIGIT_W-1:0] d);
        return (d <= 4'd9);
    endfunction

    // 10^n, used at elaboration to size-check the binary output.
    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a digit of 8 or more after the right
// shift carried a half-ten from the digit above, so take 3 back off it.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_d,
    output logic [BCD_DIGIT_W-1:0] o_d
);

    // Digits >= 8 never underflow when 3 is subtracted.
    always_comb begin
        o_d = i_d;
        if (i_d >= 4'd8) begin
            o_d = i_d - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble. One result
// bit is produced per cycle; a valid request completes in BIN_W cycles. A
// request containing a digit above 9 is rejected immediately with err set.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic                        start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic [BIN_W-1:0]            bin_out,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int     BCD_W   = BCD_DIGIT_W * DIGITS;
    localparam int     CNT_W   = $clog2(BIN_W + 1);
    localparam longint MAX_DEC = pow10(DIGITS) - 1;

    // The largest decimal input must fit in the binary output.
    if (BIN_W < 62) begin : g_width_chk
        if ((longint'(1) << BIN_W) <= MAX_DEC) begin : g_width_bad
            $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
        end
    end

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;
    logic [BIN_W-1:0]   r_bin, w_bin_nxt;
    logic [BIN_W-1:0]   r_bin_out, w_bin_out_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;

    logic [BCD_W-1:0]   w_bcd_sh;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BIN_W-1:0]   w_bin_sh;
    logic               w_in_ok;

    // The BCD and binary registers act as one long right-shift register.
    assign {w_bcd_sh, w_bin_sh} = {r_bcd, r_bin} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_d (w_bcd_sh [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_d (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Request is acceptable only if every incoming digit is 0..9.
    always_comb begin
        w_in_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_valid_digit(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                w_in_ok = 1'b0;
            end
        end
    end

    // Next-state, datapath and output decisions for the IDLE/SHIFT controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bcd_nxt     = r_bcd;
        w_bin_nxt     = r_bin;
        w_bin_out_nxt = r_bin_out;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (!w_in_ok) begin
                        w_done_nxt    = 1'b1;
                        w_err_nxt     = 1'b1;
                        w_bin_out_nxt = '0;
                    end else begin
                        w_bcd_nxt   = bcd_in;
                        w_bin_nxt   = '0;
                        w_cnt_nxt   = CNT_W'(BIN_W);
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_bcd_nxt = w_bcd_adj;
                w_bin_nxt = w_bin_sh;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_bin_out_nxt = w_bin_sh;
                    w_done_nxt    = 1'b1;
                    w_err_nxt     = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bin_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bin_out <= w_bin_out_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Shift-register contents are only meaningful in SHIFT, so no reset.
    always_ff @(posedge Clock) begin
        r_bcd <= w_bcd_nxt;
        r_bin <= w_bin_nxt;
    end

    assign bin_out = r_bin_out;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq with default parameters.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int LAT    = BIN_W;

    logic              Clock;
    logic              Resetn;
    logic              start;
    logic [11:0]       bcd_in;
    logic [BIN_W-1:0]  bin_out;
    logic              busy;
    logic              done;
    logic              err;

    int errors = 0;
    int checks = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [11:0] bcd;
        int          val;
        logic        bad;
    } vec_t;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: read the word as decimal digits, flag any digit above 9.
    function automatic void model(input logic [11:0] w, output int val, output logic bad);
        int d;
        val = 0;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'((w >> (4 * i)) & 12'hF);
            if (d > 9) bad = 1'b1;
            val = val * 10 + d;
        end
        if (bad) val = 0;
    endfunction

    // Wait for done, counting cycles after the start edge; busy must stay high.
    task automatic wait_done(input string name, output int n);
        logic busy_dropped;
        busy_dropped = 1'b0;
        n = 0;
        while (n < 4 * LAT) begin
            tick();
            n++;
            if (done) break;
            if (!busy) busy_dropped = 1'b1;
        end
        chk({name, " latency"}, n, LAT);
        chk({name, " busy held"}, busy_dropped, 0);
    endtask

    // Issue one request and check the complete response.
    task automatic run_conv(input string name, input logic [11:0] w);
        int   exp_val;
        logic exp_bad;
        int   n;
        model(w, exp_val, exp_bad);
        bcd_in = w;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        if (exp_bad) begin
            chk({name, " done"}, done, 1);
            chk({name, " err"}, err, 1);
            chk({name, " busy"}, busy, 0);
            chk({name, " bin_out"}, bin_out, 0);
        end else begin
            chk({name, " busy start"}, busy, 1);
            bcd_in = 12'($urandom);
            wait_done(name, n);
            chk({name, " bin_out"}, bin_out, exp_val);
            chk({name, " err"}, err, 0);
            chk({name, " busy end"}, busy, 0);
        end
        tick();
        chk({name, " done pulse"}, done, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int          n;
        int          dones;
        int          done_at;
        logic [11:0] w;
        int          mv;
        logic        mb;

        vecs[0] = '{bcd: 12'h999, val: 999, bad: 1'b0};
        vecs[1] = '{bcd: 12'h019, val: 19,  bad: 1'b0};
        vecs[2] = '{bcd: 12'h000, val: 0,   bad: 1'b0};
        vecs[3] = '{bcd: 12'h512, val: 512, bad: 1'b0};
        vecs[4] = '{bcd: 12'h1A5, val: 0,   bad: 1'b1};
        vecs[5] = '{bcd: 12'h007, val: 7,   bad: 1'b0};
        vecs[6] = '{bcd: 12'hF00, val: 0,   bad: 1'b1};

        // Reset held with start asserted.
        Resetn = 1'b0;
        start  = 1'b1;
        bcd_in = 12'h999;
        tick();
        tick();
        chk("reset bin_out", bin_out, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        Resetn = 1'b1;
        start  = 1'b0;
        tick();
        chk("post reset busy", busy, 0);
        chk("post reset done", done, 0);

        // Table: check the stored expectations agree with the model, then apply.
        foreach (vecs[i]) begin
            model(vecs[i].bcd, mv, mb);
            chk($sformatf("table model %0d", i), mv, vecs[i].val);
            run_conv($sformatf("vec %03h", vecs[i].bcd), vecs[i].bcd);
            chk($sformatf("vec %03h err", vecs[i].bcd), err, vecs[i].bad);
            chk($sformatf("vec %03h value", vecs[i].bcd), bin_out, vecs[i].val);
        end

        // start and bcd_in activity during a conversion must be ignored.
        bcd_in = 12'h250;
        start  = 1'b1;
        tick();
        dones   = 0;
        done_at = 0;
        for (int k = 1; k <= LAT; k++) begin
            start  = 1'($urandom);
            bcd_in = 12'($urandom);
            tick();
            if (done) begin
                dones++;
                done_at = k;
            end
        end
        chk("busy-ignore done count", dones, 1);
        chk("busy-ignore done cycle", done_at, LAT);
        chk("busy-ignore bin_out", bin_out, 250);
        // Back-to-back request in the done cycle.
        bcd_in = 12'h001;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("b2b busy", busy, 1);
        wait_done("b2b", n);
        chk("b2b bin_out", bin_out, 1);
        tick();

        // Abort a conversion with reset partway through.
        bcd_in = 12'h999;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("abort busy before", busy, 1);
        Resetn = 1'b0;
        tick();
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort bin_out", bin_out, 0);
        chk("abort err", err, 0);
        Resetn = 1'b1;
        dones  = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            if (done || busy) dones++;
        end
        chk("abort no done", dones, 0);
        run_conv("restart 123", 12'h123);

        // Random valid inputs against the model.
        for (int r = 0; r < 200; r++) begin
            w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            run_conv($sformatf("rand %03h", w), w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
